// File: rtl/if_id_queue_pkg.sv
// Shared constants for the fetch/decode instruction queue.
// Build option: IFQ_BYPASS_EN enables a zero-latency path through an empty queue.
package if_id_queue_pkg;
  localparam logic [31:0] NOP_INSN     = 32'h0000_0013;  // addi x0, x0, 0
  localparam int          IFQ_DEPTH    = 4;
  localparam int          INSN_LEN_DEF = 32;
  localparam int          ADDR_LEN_DEF = 32;
endpackage

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: circular buffer of fetched
// instructions with PC and prediction data; head shown combinationally.
// Build option: IFQ_BYPASS_EN passes enq_* straight to deq_* on an empty queue.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH    = IFQ_DEPTH,
  parameter int INSN_LEN = INSN_LEN_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       kill_i,
  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  logic [INSN_LEN-1:0]        enq_inst_i,
  input  logic [ADDR_LEN-1:0]        enq_pc_i,
  input  logic [ADDR_LEN-1:0]        enq_praddr_i,
  input  logic                       enq_prcond_i,
  input  logic                       deq_ready_i,
  output logic                       deq_valid_o,
  output logic [INSN_LEN-1:0]        deq_inst_o,
  output logic [ADDR_LEN-1:0]        deq_pc_o,
  output logic [ADDR_LEN-1:0]        deq_praddr_o,
  output logic                       deq_prcond_o,
  output logic                       deq_inv_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [INSN_LEN-1:0] r_inst   [DEPTH];
  logic [ADDR_LEN-1:0] r_pc     [DEPTH];
  logic [ADDR_LEN-1:0] r_praddr [DEPTH];
  logic [DEPTH-1:0]    r_prcond;
  logic [DEPTH-1:0]    r_vld;
  logic [PW-1:0]       r_head, r_tail;
  logic [CW-1:0]       r_count;

  logic w_empty, w_full, w_byp, w_enq, w_deq, w_head_vld;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_head_vld = r_vld[r_head];

`ifdef IFQ_BYPASS_EN
  // Empty queue forwards the incoming instruction in the same cycle.
  assign w_byp = w_empty & enq_valid_i & ~kill_i;
`else
  assign w_byp = 1'b0;
`endif

  // Ready is purely state-based: a dequeue in the same cycle does not free a slot.
  assign enq_ready_o = ~w_full;
  // A bypassed instruction that decode takes right away is never stored.
  assign w_enq = enq_valid_i & ~w_full & ~kill_i & ~(w_byp & deq_ready_i);
  assign w_deq = w_head_vld & deq_ready_i & ~kill_i;

  // Pointer, occupancy and per-entry valid state; kill wins over enq/deq.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else if (kill_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_enq) begin
        r_tail        <= r_tail + 1'b1;
        r_vld[r_tail] <= 1'b1;
      end
      if (w_deq) begin
        r_head        <= r_head + 1'b1;
        r_vld[r_head] <= 1'b0;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage; contents are only observed behind a valid bit, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_inst[r_tail]   <= enq_inst_i;
      r_pc[r_tail]     <= enq_pc_i;
      r_praddr[r_tail] <= enq_praddr_i;
      r_prcond[r_tail] <= enq_prcond_i;
    end
  end

  // Head presentation: stored entry, bypassed input, or an invalid NOP.
  always_comb begin
    deq_valid_o  = 1'b0;
    deq_inst_o   = INSN_LEN'(NOP_INSN);
    deq_pc_o     = '0;
    deq_praddr_o = '0;
    deq_prcond_o = 1'b0;
    if (w_head_vld) begin
      deq_valid_o  = 1'b1;
      deq_inst_o   = r_inst[r_head];
      deq_pc_o     = r_pc[r_head];
      deq_praddr_o = r_praddr[r_head];
      deq_prcond_o = r_prcond[r_head];
    end else if (w_byp) begin
      deq_valid_o  = 1'b1;
      deq_inst_o   = enq_inst_i;
      deq_pc_o     = enq_pc_i;
      deq_praddr_o = enq_praddr_i;
      deq_prcond_o = enq_prcond_i;
    end
  end

  assign deq_inv_o = ~deq_valid_o;
  assign count_o   = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_ni, kill_i, enq_valid_i, enq_prcond_i, deq_ready_i;
  logic [31:0]   enq_inst_i, enq_pc_i, enq_praddr_i;
  logic          enq_ready_o, deq_valid_o, deq_prcond_o, deq_inv_o;
  logic [31:0]   deq_inst_o, deq_pc_o, deq_praddr_o;
  logic [CW-1:0] count_o;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(DEPTH), .INSN_LEN(32), .ADDR_LEN(32)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .kill_i(kill_i),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
    .enq_inst_i(enq_inst_i), .enq_pc_i(enq_pc_i),
    .enq_praddr_i(enq_praddr_i), .enq_prcond_i(enq_prcond_i),
    .deq_ready_i(deq_ready_i), .deq_valid_o(deq_valid_o),
    .deq_inst_o(deq_inst_o), .deq_pc_o(deq_pc_o),
    .deq_praddr_o(deq_praddr_o), .deq_prcond_o(deq_prcond_o),
    .deq_inv_o(deq_inv_o), .count_o(count_o)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pra;
    logic        prc;
  } ent_t;

  ent_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit bypass_now();
    bit b = 1'b0;
`ifdef IFQ_BYPASS_EN
    b = (q.size() == 0) && enq_valid_i && !kill_i;
`endif
    return b;
  endfunction

  // Compare every output with what the model says should be visible now.
  task automatic check_outs(input string tag);
    ent_t e;
    bit   v;
    v = (q.size() != 0) || bypass_now();
    if (q.size() != 0)  e = q[0];
    else if (v)         e = '{enq_inst_i, enq_pc_i, enq_praddr_i, enq_prcond_i};
    else                e = '{32'h13, 32'h0, 32'h0, 1'b0};
    chk({tag, ".valid"},  64'(deq_valid_o),  64'(v));
    chk({tag, ".inv"},    64'(deq_inv_o),    64'(!v));
    chk({tag, ".inst"},   64'(deq_inst_o),   64'(e.inst));
    chk({tag, ".pc"},     64'(deq_pc_o),     64'(e.pc));
    chk({tag, ".praddr"}, 64'(deq_praddr_o), 64'(e.pra));
    chk({tag, ".prcond"}, 64'(deq_prcond_o), 64'(e.prc));
    chk({tag, ".count"},  64'(count_o),      64'(q.size()));
    chk({tag, ".ready"},  64'(enq_ready_o),  64'(q.size() != DEPTH));
  endtask

  // One cycle: drive at negedge, check before the edge, then advance the model.
  task automatic step(input string tag, input bit k, input bit ev, input logic [31:0] inst,
                      input logic [31:0] pc, input bit dr);
    bit   rdy, byp;
    ent_t e;
    kill_i       = k;
    enq_valid_i  = ev;
    enq_inst_i   = inst;
    enq_pc_i     = pc;
    enq_praddr_i = pc + 32'h40;
    enq_prcond_i = pc[2];
    deq_ready_i  = dr;
    #1;
    check_outs(tag);
    rdy = (q.size() != DEPTH);
    byp = bypass_now();
    e   = '{inst, pc, pc + 32'h40, pc[2]};
    @(posedge clk);
    if (k) q.delete();
    else if (!(byp && dr)) begin
      if (q.size() != 0 && dr) void'(q.pop_front());
      if (ev && rdy) q.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin
    reset_ni = 1'b0; kill_i = 1'b0; enq_valid_i = 1'b0; deq_ready_i = 1'b0;
    enq_inst_i = '0; enq_pc_i = '0; enq_praddr_i = '0; enq_prcond_i = 1'b0;
    repeat (2) @(negedge clk);
    check_outs("reset");
    reset_ni = 1'b1;

    step("idle", 0, 0, 32'h0, 32'h0, 1);
    // Single enqueue, visible after one edge.
    step("enq1", 0, 1, 32'h0050_0093, 32'h100, 0);
    step("enq1_vis", 0, 0, 32'h0, 32'h0, 0);
    // Fill to four, try a fifth, then drain in order.
    for (int i = 1; i < 4; i++) step("fill", 0, 1, 32'h1000 + i, 32'h100 + 4 * i, 0);
    step("full_refuse", 0, 1, 32'hdead_beef, 32'h200, 0);
    step("full_refuse_dr", 0, 1, 32'hbad0_0001, 32'h204, 1);
    for (int i = 0; i < 5; i++) step("drain", 0, 0, 32'h0, 32'h0, 1);
    // Streaming with wrap: one per cycle.
    for (int i = 0; i < 10; i++) step("stream", 0, 1, 32'h2000 + i, 32'h300 + 4 * i, 1);
    step("stream_tail", 0, 0, 32'h0, 32'h0, 1);
    // Kill with a concurrent enqueue.
    for (int i = 0; i < 3; i++) step("kfill", 0, 1, 32'h3000 + i, 32'h400 + 4 * i, 0);
    step("kill", 1, 1, 32'h3fff, 32'h4fc, 1);
    step("post_kill", 0, 0, 32'h0, 32'h0, 0);
    // Asynchronous reset between edges with two entries held.
    for (int i = 0; i < 2; i++) step("rfill", 0, 1, 32'h4000 + i, 32'h500 + 4 * i, 0);
    enq_valid_i = 1'b0;
    #2 reset_ni = 1'b0;
    q.delete();
    #1 check_outs("async_rst");
    @(negedge clk);
    reset_ni = 1'b1;
    step("post_rst", 0, 0, 32'h0, 32'h0, 1);
    // Random traffic against the model.
    for (int i = 0; i < 300; i++)
      step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6), $urandom,
           {$urandom_range(0, 255), 2'b00}, $urandom_range(0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end
endmodule
